// File: rtl/bemicro_cv_pb_pkg.sv
// Shared constants and helpers for the BeMicro CV push-button/switch conditioning logic.
package bemicro_cv_pb_pkg;

  localparam int unsigned PB_WIDTH               = 2;
  localparam int unsigned PB_STABLE_CYCLES_50MHZ = 500000;

  // Debounce counter width; at least one bit so STABLE_CYCLES=1 still builds.
  function automatic int unsigned pb_cnt_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bemicro_cv_pb_debounce_if.sv
// Pin-side input and PIO-side conditioned outputs of the push-button debouncer.
interface bemicro_cv_pb_debounce_if
  import bemicro_cv_pb_pkg::*;
#(
  parameter int unsigned WIDTH = PB_WIDTH
);

  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             change_o;

  // master: the debouncer; slave: pins in, PIO / IRQ logic out
  modport master (
    input  pin_in,
    output db_out,
    output rise_o,
    output fall_o,
    output change_o
  );

  modport slave (
    output pin_in,
    input  db_out,
    input  rise_o,
    input  fall_o,
    input  change_o
  );

endinterface

// File: rtl/bemicro_cv_pb_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, polarity normalisation, stability counter.
// Press/release strobes exist only when PB_DEBOUNCE_EDGE_EN is defined.
module bemicro_cv_pb_debounce_ch
  import bemicro_cv_pb_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = PB_STABLE_CYCLES_50MHZ,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned         CntW   = pb_cnt_w(STABLE_CYCLES);
  localparam logic [CntW-1:0]     CntMax = CntW'(STABLE_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Reset value 0 is the deasserted (idle) level after normalisation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pin_i ^ ACTIVE_LOW;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;

`ifdef PB_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Registered from db_d so the strobe lines up with the new db_o level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= db_d & ~db_q;
      fall_q <= ~db_d & db_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/bemicro_cv_pb_debounce.sv
// Debounces WIDTH raw push-button/switch pins for the pb_sw PIO.
// Define PB_DEBOUNCE_EDGE_EN to build the rise/fall/change strobes; otherwise they read 0.
module bemicro_cv_pb_debounce
  import bemicro_cv_pb_pkg::*;
#(
  parameter int unsigned WIDTH         = PB_WIDTH,
  parameter int unsigned STABLE_CYCLES = PB_STABLE_CYCLES_50MHZ,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  bemicro_cv_pb_debounce_if.master   pb
);

  logic [WIDTH-1:0] db_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    bemicro_cv_pb_debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (pb.pin_in[i]),
      .db_o    (db_w[i]),
      .rise_o  (rise_w[i]),
      .fall_o  (fall_w[i])
    );
  end

  assign pb.db_out   = db_w;
  assign pb.rise_o   = rise_w;
  assign pb.fall_o   = fall_w;
  assign pb.change_o = |(rise_w | fall_w);

endmodule

// File: tb/tb_bemicro_cv_pb_debounce.sv
// Randomised + directed bench for bemicro_cv_pb_debounce with a window-based reference model.
module tb_bemicro_cv_pb_debounce;

  localparam int unsigned W = 2;
  localparam int unsigned N = 4;

  typedef struct packed {
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         change;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   started  = 1'b0;
  bit   done     = 1'b0;

  exp_t exp_q[$];

  bemicro_cv_pb_debounce_if #(.WIDTH(W)) pb_if ();

  bemicro_cv_pb_debounce #(
    .WIDTH         (W),
    .STABLE_CYCLES (N),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pb      (pb_if)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last N synchronised samples all
  // disagree with the current debounced level.
  initial begin : model
    logic [W-1:0] s1, s2, s2pre, db, old;
    logic [W-1:0] win[$];
    exp_t e;
    bit all_diff;
    s1 = '0; s2 = '0; db = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        s1 = '0; s2 = '0; db = '0;
        win.delete();
        exp_q.delete();
        exp_q.push_back('0);
      end else begin
        s2pre = s2;
        s2    = s1;
        s1    = ~pb_if.pin_in;
        win.push_back(s2pre);
        if (win.size() > N) void'(win.pop_front());
        old = db;
        for (int ch = 0; ch < W; ch++) begin
          all_diff = (win.size() == N);
          foreach (win[j]) if (win[j][ch] == old[ch]) all_diff = 1'b0;
          if (all_diff) db[ch] = ~old[ch];
        end
        e.db = db;
`ifdef PB_DEBOUNCE_EDGE_EN
        e.rise   = db & ~old;
        e.fall   = ~db & old;
        e.change = |(db ^ old);
`else
        e.rise   = '0;
        e.fall   = '0;
        e.change = 1'b0;
`endif
        exp_q.push_back(e);
      end
      started = 1'b1;
    end
  end

  // Monitor: one expected entry per clock, compared on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (started && !done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard_empty t=%0t actual=empty required=entry", $time);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (pb_if.db_out !== e.db) begin
            n_errors++;
            $display("FAIL db_out t=%0t actual=%b required=%b", $time, pb_if.db_out, e.db);
          end
          n_checks++;
          if ({pb_if.rise_o, pb_if.fall_o, pb_if.change_o} !== {e.rise, e.fall, e.change}) begin
            n_errors++;
            $display("FAIL strobes t=%0t actual rise=%b fall=%b chg=%b required rise=%b fall=%b chg=%b",
                     $time, pb_if.rise_o, pb_if.fall_o, pb_if.change_o, e.rise, e.fall, e.change);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [W-1:0] p, input int n);
    pb_if.pin_in = p;
    cyc(n);
  endtask

  task automatic pulse_reset(input int n);
    reset_n = 1'b0;
    cyc(n);
    reset_n = 1'b1;
  endtask

  initial begin : stim
    reset_n      = 1'b0;
    pb_if.pin_in = 2'b11;
    cyc(20);
    reset_n = 1'b1;
    cyc(4);
    // single press / release on channel 0
    drive(2'b10, 10);
    drive(2'b11, 10);
    // glitch shorter than the window, then an accepted press
    drive(2'b10, 3);
    drive(2'b11, 8);
    drive(2'b10, 6);
    drive(2'b11, 10);
    // simultaneous press and release on both channels
    drive(2'b00, 10);
    drive(2'b11, 10);
    // reset mid-count with channel 1 held pressed
    drive(2'b01, 3);
    pulse_reset(2);
    drive(2'b01, 10);
    drive(2'b11, 10);
    // random hold lengths around the window, occasional resets
    for (int i = 0; i < 600; i++) begin
      drive(W'($urandom), $urandom_range(1, 8));
      if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 3));
    end
    drive(2'b11, 12);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
